// File: rtl/cache_axi_bridge.sv
// Cache-to-AXI3 bridge. Independent read and write FSMs. Reads go out as a
// single-beat or 4-beat INCR burst, and return data passes straight through
// to the cache. Writes capture a 128-bit line buffer and drive the AW and W
// channels independently.
module cache_axi_bridge #(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  // cache read side
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [1:0]   ret_last,
  output logic [31:0]  ret_data,
  // cache write side
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  // AXI AR
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  // AXI R
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // AXI AW
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [1:0]   awlock,
  output logic [3:0]   awcache,
  output logic [2:0]   awprot,
  output logic         awvalid,
  input  logic         awready,
  // AXI W
  output logic [3:0]   wid,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  // AXI B
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

  r_state_e       r_state_q, r_state_d;
  logic [31:0]    rd_addr_q, rd_addr_d;
  logic [2:0]     rd_type_q, rd_type_d;

  w_state_e       w_state_q, w_state_d;
  logic [31:0]    wbuf_addr_q, wbuf_addr_d;
  logic [2:0]     wbuf_type_q, wbuf_type_d;
  logic [3:0]     wbuf_strb_q, wbuf_strb_d;
  logic [127:0]   wbuf_data_q, wbuf_data_d;
  logic [1:0]     w_cnt_q, w_cnt_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;

  logic           rd_line, wr_line, raw_hazard, aw_hs, w_hs;
  logic           unused_rid;

  assign unused_rid = ^rid;

  assign rd_line = (rd_type_q == 3'b100);
  assign wr_line = (wbuf_type_q == 3'b100);

  // A read to the line currently being written must wait for the write response.
  assign raw_hazard = (w_state_q != W_IDLE) && (rd_addr[31:4] == wbuf_addr_q[31:4]);

  assign rd_rdy    = !reset && (r_state_q == R_IDLE) && !raw_hazard;
  assign arvalid   = !reset && (r_state_q == R_AR);
  assign arid      = RD_ID;
  assign araddr    = rd_addr_q;
  assign arlen     = rd_line ? 8'd3 : 8'd0;
  assign arsize    = rd_line ? 3'd2 : {1'b0, rd_type_q[1:0]};
  assign arburst   = 2'b01;
  assign arlock    = '0;
  assign arcache   = '0;
  assign arprot    = '0;

  assign rready    = !reset && (r_state_q == R_DATA);
  assign ret_valid = rready && rvalid;
  assign ret_data  = rdata;
  assign ret_last  = {1'b0, rlast};

  assign wr_rdy    = !reset && (w_state_q == W_IDLE);
  assign awvalid   = !reset && (w_state_q == W_SEND) && !aw_done_q;
  assign awid      = WR_ID;
  assign awaddr    = wbuf_addr_q;
  assign awlen     = wr_line ? 8'd3 : 8'd0;
  assign awsize    = wr_line ? 3'd2 : {1'b0, wbuf_type_q[1:0]};
  assign awburst   = 2'b01;
  assign awlock    = '0;
  assign awcache   = '0;
  assign awprot    = '0;

  assign wvalid    = !reset && (w_state_q == W_SEND) && !w_done_q;
  assign wid       = WR_ID;
  assign wdata     = wbuf_data_q[{w_cnt_q, 5'd0} +: 32];
  assign wstrb     = wr_line ? 4'hf : wbuf_strb_q;
  assign wlast     = (w_cnt_q == awlen[1:0]);
  assign bready    = !reset && (w_state_q == W_RESP);

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  // Next-state logic for both FSMs and their capture registers.
  always_comb begin
    r_state_d   = r_state_q;
    rd_addr_d   = rd_addr_q;
    rd_type_d   = rd_type_q;
    w_state_d   = w_state_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_type_d = wbuf_type_q;
    wbuf_strb_d = wbuf_strb_q;
    wbuf_data_d = wbuf_data_q;
    w_cnt_d     = w_cnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;

    unique case (r_state_q)
      R_IDLE: if (rd_req && rd_rdy) begin
        r_state_d = R_AR;
        rd_addr_d = rd_addr;
        rd_type_d = rd_type;
      end
      R_AR:   if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase

    unique case (w_state_q)
      W_IDLE: if (wr_req && wr_rdy) begin
        w_state_d   = W_SEND;
        wbuf_addr_d = wr_addr;
        wbuf_type_d = wr_type;
        wbuf_strb_d = wr_wstrb;
        wbuf_data_d = wr_data;
        w_cnt_d     = '0;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
      end
      W_SEND: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          w_cnt_d = w_cnt_q + 2'd1;
          if (wlast) w_done_d = 1'b1;
        end
        // AW and the last W may complete in either order or together.
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast)))
          w_state_d = W_RESP;
      end
      W_RESP: if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // State registers; capture buffers are not reset since they are reloaded on accept.
  always_ff @(posedge clk) begin
    rd_addr_q   <= rd_addr_d;
    rd_type_q   <= rd_type_d;
    wbuf_addr_q <= wbuf_addr_d;
    wbuf_type_q <= wbuf_type_d;
    wbuf_strb_q <= wbuf_strb_d;
    wbuf_data_q <= wbuf_data_d;
    if (reset) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 Parameters: RD_ID default 4'd0, ARID value; WR_ID default 4'd1, AWID/WID value.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 Cache read side: rd_req in 1; rd_type in 3 (000 byte, 001 half, 010 word, 100 line); rd_addr in 32; rd_rdy out 1.
REQ-005 Cache return side: ret_valid out 1; ret_last out 2 (bit0 = last beat, bit1 = 0); ret_data out 32.
REQ-006 Cache write side: wr_req in 1; wr_type in 3; wr_addr in 32; wr_wstrb in 4; wr_data in 128; wr_rdy out 1.
REQ-007 AXI AR: arvalid out 1; arready in 1; araddr out 32; arlen out 8; arsize out 3; arid out 4.
REQ-008 AXI R: rvalid in 1; rready out 1; rdata in 32; rlast in 1; rid in 4 (ignored).
REQ-009 AXI AW: awvalid out 1; awready in 1; awaddr out 32; awlen out 8; awsize out 3; awid out 4.
REQ-010 AXI W: wvalid out 1; wready in 1; wdata out 32; wstrb out 4; wlast out 1; wid out 4.
REQ-011 AXI B: bvalid in 1; bready out 1.
REQ-012 Constant outputs: arburst = awburst = 2'b01; arlock = awlock = 0; arcache = awcache = 4'b0; arprot = awprot = 3'b0.

Function
REQ-013 Read FSM states: R_IDLE, R_AR, R_DATA.
- R_IDLE -> R_AR on rd_req & rd_rdy.
- Same cycle: latch rd_addr and rd_type.
REQ-014 Read request encoding: arlen = 3 if latched type = 100, else 0; arsize = 2 for line, else type[1:0]; araddr = latched address unmodified.
REQ-015 arvalid = 1 only in R_AR, held stable until arready; R_AR -> R_DATA on arvalid & arready.
REQ-016 In R_DATA: rready = 1; ret_valid = rvalid; ret_data = rdata; ret_last = {1'b0, rlast}. R_DATA -> R_IDLE on rvalid & rlast.
REQ-017 Zero-bubble read path: no added latency; rdata reaches ret_data combinationally in the beat cycle.
REQ-018 rd_rdy = 1 in R_IDLE, except 0 while the write FSM is not W_IDLE and rd_addr[31:4] == latched write address[31:4] (RAW hazard).
REQ-019 Write FSM states: W_IDLE, W_SEND, W_RESP.
- W_IDLE -> W_SEND on wr_req & wr_rdy.
- Same cycle: latch wr_addr, wr_type, wr_wstrb, wr_data into write buffer; clear beat counter (2 bits).
REQ-020 wr_rdy = 1 only in W_IDLE (the cache samples wr_rdy before raising wr_req).
REQ-021 Write request encoding: awlen = 3 for line, else 0; awsize as REQ-014; awaddr = latched wr_addr.
REQ-022 In W_SEND, awvalid and wvalid are asserted independently:
- awvalid drops after the aw handshake.
- wvalid drops after the last-beat handshake.
- Either handshake may occur first or both in the same cycle.
REQ-023 W beats:
- wdata = buffer word [32*cnt+31 : 32*cnt]; cnt increments per w handshake.
- wstrb = 4'hf for line, latched wr_wstrb otherwise.
- wlast = (cnt == awlen[1:0]).
REQ-024 W_SEND -> W_RESP when both aw and last w handshakes are complete (tracked by done flags, cleared on entry). bready = 1 in W_RESP; W_RESP -> W_IDLE on bvalid. bresp is ignored.
REQ-025 Read and write FSMs run concurrently; a read to a different line proceeds while a write is in flight.
REQ-026 AXI stability: address, len, size and data stay constant while valid is high without ready.

Reset
REQ-027 While reset = 1 (sampled at posedge):
- FSMs go to R_IDLE/W_IDLE; beat counter and done flags clear.
- arvalid, awvalid, wvalid, rready, bready, ret_valid, rd_rdy and wr_rdy are 0.
- Write buffer contents are don't-care.
REQ-028 Reset mid-burst abandons the transaction without completing it; the AXI slave is reset in the same cycle.

Verification
REQ-029 Line read, arready delayed 2 cycles:
- Stimulus: rd_req, type 100, addr 0x1c000120; rdata 0xA0..0xA3, rvalid gapped on beat 2.
- Required: arlen = 3, arsize = 2; four ret_valid pulses with the same data; ret_last = 01 only on 0xA3.
REQ-030 Uncached byte read:
- Stimulus: type 000, addr 0xbfaf8003.
- Required: arlen = 0, arsize = 0, one ret_valid with ret_last = 01.
REQ-031 Line write, wready before awready:
- Stimulus: wr_data = {D3,D2,D1,D0}.
- Required: beats D0..D3 with wstrb f, wlast only on D3; W_RESP is entered only after awready; wr_rdy returns to 1 the cycle after bvalid.
REQ-032 Single-word write:
- Stimulus: wstrb 0110, addr 0x1faf0004.
- Required: awlen = 0, wdata = wr_data[31:0], wstrb = 0110, wlast = 1.
REQ-033 RAW hazard:
- Stimulus: line write to 0x00001230 outstanding; rd_req to 0x0000123c.
- Required: rd_rdy = 0 until the bvalid cycle completes; rd_req to 0x00002000 in the same window is accepted immediately.
REQ-034 Reset asserted during R_DATA beat 2 -> next cycle all valid/ready outputs are 0; a fresh read afterward completes normally.
